// File: rtl/alu_divider.sv
// Restoring divider, 4-bit dividend by 2-bit divisor; one quotient bit per clock.
// Define ALU_DIV_EARLY_EXIT_EN to finish divisor==1 and dividend<divisor requests in one cycle.
module alu_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [3:0] dividend_i,
  input  logic [1:0] divisor_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] quotient_o,
  output logic [1:0] remainder_o,
  output logic       div_zero_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] p_q, p_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] dvd_q, dvd_d;
  logic [1:0] dvs_q, dvs_d;
  logic [3:0] quot_q, quot_d;
  logic [1:0] rem_q, rem_d;
  logic       dz_q, dz_d;

  logic [2:0] p_shift, p_sub, p_next;
  logic       q_bit;

  // P stays below 2*divisor, so a 3-bit compare/subtract covers every step.
  assign p_shift = {p_q[1:0], dvd_q[3]};
  assign p_sub   = p_shift - {1'b0, dvs_q};
  assign q_bit   = (p_shift >= {1'b0, dvs_q});
  assign p_next  = q_bit ? p_sub : p_shift;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          dvd_d  = dividend_i;
          dvs_d  = divisor_i;
          p_d    = 3'd0;
          cnt_d  = 2'd0;
          quot_d = 4'd0;
          rem_d  = 2'd0;
          dz_d   = 1'b0;
          if (divisor_i == 2'd0) begin
            state_d = S_DONE;
            quot_d  = 4'hF;
            dz_d    = 1'b1;
          end
`ifdef ALU_DIV_EARLY_EXIT_EN
          else if (divisor_i == 2'd1) begin
            state_d = S_DONE;
            quot_d  = dividend_i;
          end else if (dividend_i < {2'b00, divisor_i}) begin
            state_d = S_DONE;
            rem_d   = dividend_i[1:0];
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        p_d    = p_next;
        dvd_d  = {dvd_q[2:0], 1'b0};
        quot_d = {quot_q[2:0], q_bit};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_DONE;
          rem_d   = p_next[1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= 3'd0;
      cnt_q   <= 2'd0;
      dvd_q   <= 4'd0;
      dvs_q   <= 2'd0;
      quot_q  <= 4'd0;
      rem_q   <= 2'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o      = (state_q == S_CALC);
  assign done_o      = (state_q == S_DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule
